// File: rtl/gshare_btb_pred_if.sv
// Predictor port bundle: fetch lookup, dispatch checkpointing and branch resolve.
// ROB_W must equal $clog2(ROB_SIZE) of the attached predictor.
interface gshare_btb_pred_if #(parameter int ROB_W = 4);
    // fetch lookup
    logic              pred_req;
    logic [31:0]       pred_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [31:0]       pred_target;
    // dispatch
    logic              dispatch_en;
    logic [ROB_W-1:0]  dispatch_rob_id;
    logic [31:0]       dispatch_pc;
    logic              dispatch_is_br;
    logic              dispatch_is_call;
    logic              dispatch_is_ret;
    logic              dispatch_pred_taken;
    // resolve
    logic              resolve_en;
    logic [ROB_W-1:0]  resolve_rob_id;
    logic [31:0]       resolve_pc;
    logic [1:0]        resolve_type;
    logic              resolve_taken;
    logic [31:0]       resolve_target;
    logic              resolve_mispredict;

    modport master (
        output pred_req, pred_pc,
        output dispatch_en, dispatch_rob_id, dispatch_pc, dispatch_is_br,
               dispatch_is_call, dispatch_is_ret, dispatch_pred_taken,
        output resolve_en, resolve_rob_id, resolve_pc, resolve_type,
               resolve_taken, resolve_target, resolve_mispredict,
        input  pred_valid, pred_taken, pred_target
    );

    modport slave (
        input  pred_req, pred_pc,
        input  dispatch_en, dispatch_rob_id, dispatch_pc, dispatch_is_br,
               dispatch_is_call, dispatch_is_ret, dispatch_pred_taken,
        input  resolve_en, resolve_rob_id, resolve_pc, resolve_type,
               resolve_taken, resolve_target, resolve_mispredict,
        output pred_valid, pred_taken, pred_target
    );
endinterface

// File: rtl/gshare_btb_pred.sv
// gshare direction predictor + direct-mapped BTB with per-ROB-slot history
// checkpoints. Optional return address stack enabled by defining RAS_EN.
module gshare_btb_pred #(
    parameter int LG_PHT    = 7,
    parameter int LG_BTB    = 5,
    parameter int GHR_W     = 7,   // 1..LG_PHT
    parameter int TAG_W     = 10,
    parameter int ROB_SIZE  = 16,
    parameter int RAS_DEPTH = 8    // power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst,
    gshare_btb_pred_if.slave bus
);
    localparam int PHT_N = 1 << LG_PHT;
    localparam int BTB_N = 1 << LG_BTB;
    localparam logic [1:0] T_BR = 2'd0;

    typedef logic [LG_PHT-1:0] pht_idx_t;
    typedef logic [GHR_W-1:0]  ghr_t;
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       typ;
    } btb_ent_t;

    ghr_t             ghr;
    logic [1:0]       pht    [PHT_N];
    logic [BTB_N-1:0] btb_vld;
    btb_ent_t         btb    [BTB_N];
    ghr_t             ck_ghr [ROB_SIZE];
    pht_idx_t         ck_idx [ROB_SIZE];

    // Shift a new outcome into the history; the oldest bit falls off the top.
    function automatic ghr_t ghr_shift(ghr_t g, logic b);
        return GHR_W'({g, b});
    endfunction

    // lookup path, all from pre-edge state
    pht_idx_t          lk_idx;
    logic [LG_BTB-1:0] lk_bi;
    btb_ent_t          lk_e;
    logic              lk_hit, lk_taken;
    logic [31:0]       lk_target;
    assign lk_idx = bus.pred_pc[LG_PHT+1:2] ^ LG_PHT'(ghr);
    assign lk_bi  = bus.pred_pc[LG_BTB+1:2];
    assign lk_e   = btb[lk_bi];
    assign lk_hit = btb_vld[lk_bi] && (lk_e.tag == bus.pred_pc[LG_BTB+2 +: TAG_W]);

    // resolve / dispatch side indices
    pht_idx_t          rs_idx, dp_idx;
    ghr_t              rs_ghr;
    logic [LG_BTB-1:0] rs_bi;
    logic              restore;
    assign rs_idx  = ck_idx[bus.resolve_rob_id];
    assign rs_ghr  = ck_ghr[bus.resolve_rob_id];
    assign rs_bi   = bus.resolve_pc[LG_BTB+1:2];
    assign dp_idx  = bus.dispatch_pc[LG_PHT+1:2] ^ LG_PHT'(ghr);
    assign restore = bus.resolve_en && bus.resolve_mispredict;

`ifdef RAS_EN
    localparam int RAS_W = $clog2(RAS_DEPTH);
    localparam logic [1:0] T_RET = 2'd3;
    logic [31:0]      ras        [RAS_DEPTH];
    logic [RAS_W-1:0] ras_ptr;
    logic [RAS_W:0]   ras_cnt;
    logic [RAS_W-1:0] ck_ras_ptr [ROB_SIZE];
    logic [RAS_W:0]   ck_ras_cnt [ROB_SIZE];
    logic             push, pop;
    assign push = bus.dispatch_en && bus.dispatch_is_call;
    assign pop  = bus.dispatch_en && bus.dispatch_is_ret && (ras_cnt != '0);

    // Circular stack: push always advances, count saturates so a full stack drops its oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (restore) begin
            ras_ptr <= ck_ras_ptr[bus.resolve_rob_id];
            ras_cnt <= ck_ras_cnt[bus.resolve_rob_id];
        end else if (push) begin
            ras_ptr <= ras_ptr + RAS_W'(1);
            if (ras_cnt != (RAS_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RAS_W+1)'(1);
        end else if (pop) begin
            ras_ptr <= ras_ptr - RAS_W'(1);
            ras_cnt <= ras_cnt - (RAS_W+1)'(1);
        end
    end

    // Stack data; a push that loses to a restore must not clobber a restored live entry.
    always_ff @(posedge clk) begin
        if (!rst && push && !restore) ras[ras_ptr] <= bus.dispatch_pc + 32'd4;
    end

    // RAS position checkpoint alongside the history checkpoint.
    always_ff @(posedge clk) begin
        if (bus.dispatch_en) begin
            ck_ras_ptr[bus.dispatch_rob_id] <= ras_ptr;
            ck_ras_cnt[bus.dispatch_rob_id] <= ras_cnt;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{bus.dispatch_is_call, bus.dispatch_is_ret, 32'(RAS_DEPTH)};
`endif

    logic unused_pc;
    assign unused_pc = ^{bus.pred_pc, bus.dispatch_pc, bus.resolve_pc};

    // Direction and target of the current fetch lookup.
    always_comb begin
        lk_taken  = lk_hit && ((lk_e.typ != T_BR) || pht[lk_idx][1]);
        lk_target = lk_hit ? lk_e.target : bus.pred_pc + 32'd4;
`ifdef RAS_EN
        if (lk_hit && (lk_e.typ == T_RET) && (ras_cnt != '0))
            lk_target = ras[ras_ptr - RAS_W'(1)];
`endif
    end

    // One-cycle registered lookup response.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pred_valid  <= 1'b0;
            bus.pred_taken  <= 1'b0;
            bus.pred_target <= '0;
        end else begin
            bus.pred_valid  <= bus.pred_req;
            bus.pred_taken  <= bus.pred_req && lk_taken;
            bus.pred_target <= lk_target;
        end
    end

    // Global history: mispredict restore beats speculative dispatch shift.
    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (restore)
            ghr <= (bus.resolve_type == T_BR) ? ghr_shift(rs_ghr, bus.resolve_taken) : rs_ghr;
        else if (bus.dispatch_en && bus.dispatch_is_br)
            ghr <= ghr_shift(ghr, bus.dispatch_pred_taken);
    end

    // Per-slot snapshot of history and PHT index taken at dispatch.
    always_ff @(posedge clk) begin
        if (bus.dispatch_en) begin
            ck_ghr[bus.dispatch_rob_id] <= ghr;
            ck_idx[bus.dispatch_rob_id] <= dp_idx;
        end
    end

    // Saturating 2-bit counters trained at the checkpointed index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else if (bus.resolve_en && (bus.resolve_type == T_BR)) begin
            if (bus.resolve_taken && (pht[rs_idx] != 2'b11))
                pht[rs_idx] <= pht[rs_idx] + 2'd1;
            else if (!bus.resolve_taken && (pht[rs_idx] != 2'b00))
                pht[rs_idx] <= pht[rs_idx] - 2'd1;
        end
    end

    // BTB valid bits.
    always_ff @(posedge clk) begin
        if (rst)
            btb_vld <= '0;
        else if (bus.resolve_en && bus.resolve_taken)
            btb_vld[rs_bi] <= 1'b1;
    end

    // BTB payload, allocated only by taken resolves.
    always_ff @(posedge clk) begin
        if (!rst && bus.resolve_en && bus.resolve_taken)
            btb[rs_bi] <= '{tag: bus.resolve_pc[LG_BTB+2 +: TAG_W],
                            target: bus.resolve_target, typ: bus.resolve_type};
    end
endmodule

// File: doc/gshare_btb_pred.md
GSHARE_BTB_PRED -- requirements
Module: gshare_btb_pred

Interface
REQ-001 Parameter LG_PHT, 7, log2 of PHT entry count.
REQ-002 Parameter LG_BTB, 5, log2 of BTB entry count.
REQ-003 Parameter GHR_W, 7, global history length; legal range 1..LG_PHT.
REQ-004 Parameter TAG_W, 10, BTB tag width taken from pc[LG_BTB+2+:TAG_W].
REQ-005 Parameter ROB_SIZE, 16, checkpoint slots; ROB_W = clog2(ROB_SIZE).
REQ-006 Parameter RAS_DEPTH, 8, return stack entries, power of two.
REQ-007 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-008 pred_req  in  1  fetch lookup strobe; pred_pc  in  32  fetch PC.
REQ-009 pred_valid  out  1  lookup result valid; pred_taken  out  1  redirect fetch; pred_target  out  32  redirect PC.
REQ-010 dispatch_en  in  1; dispatch_rob_id  in  ROB_W; dispatch_pc  in  32; dispatch_is_br  in  1  conditional branch; dispatch_is_call  in  1; dispatch_is_ret  in  1; dispatch_pred_taken  in  1.
REQ-011 resolve_en  in  1; resolve_rob_id  in  ROB_W; resolve_pc  in  32; resolve_type  in  2  (0 BR, 1 JMP, 2 CALL, 3 RET); resolve_taken  in  1; resolve_target  in  32; resolve_mispredict  in  1.

Function
REQ-012 Lookup index = pred_pc[LG_PHT+1:2] XOR zero-extended GHR; BTB index = pred_pc[LG_BTB+1:2].
REQ-013 Lookup latency exactly 1 cycle: pred_valid is the registered pred_req; results are computed from state before the edge (no write-through on same-cycle updates).
REQ-014 BTB hit = entry valid AND stored tag equals pred_pc tag field.
REQ-015 pred_taken = hit AND (type != BR OR PHT counter[1]); otherwise 0.
REQ-016 pred_target = BTB target on hit, pred_pc+4 otherwise; RET target per REQ-027.
REQ-017 Dispatch with dispatch_is_br: GHR <= {GHR[GHR_W-2:0], dispatch_pred_taken}; checkpoint slot dispatch_rob_id stores pre-shift GHR and the PHT index formed from dispatch_pc.
REQ-018 Dispatch without dispatch_is_br: GHR unchanged; checkpoint still written.
REQ-019 Resolve of type BR: 2-bit counter at checkpointed PHT index incremented if resolve_taken else decremented, saturating at 3 and 0.
REQ-020 Resolve with resolve_taken: BTB entry at resolve_pc index written with valid=1, tag, resolve_target, resolve_type; not-taken resolve leaves BTB unchanged.
REQ-021 Resolve with resolve_mispredict: GHR <= checkpoint GHR shifted with resolve_taken if type BR, checkpoint GHR unshifted otherwise.
REQ-022 Same-cycle dispatch and mispredict resolve: mispredict restore wins, dispatch GHR shift dropped; checkpoint write still occurs.
REQ-023 Same-cycle dispatch and non-mispredict resolve: both take effect independently.
REQ-024 All outputs and counter updates are width-exact; pred_pc+4 wraps modulo 2^32.

Reset
REQ-025 On rst: GHR=0, all PHT counters=2'b01, all BTB valid=0, pred_valid=0, pred_taken=0, pred_target=0, RAS pointer=0, RAS count=0; rst mid-lookup discards the pending result.
REQ-026 Checkpoint arrays are not reset; they are only read for slots written since reset.

Configuration
REQ-027 With RAS_EN defined: dispatch_is_call pushes dispatch_pc+4 (full stack overwrites oldest, count saturates at RAS_DEPTH); dispatch_is_ret pops (empty: no-op); BTB hit of type RET predicts RAS top, or BTB target when empty; pointer and count checkpointed per ROB slot and restored on mispredict.
REQ-028 Without RAS_EN: no stack storage; dispatch_is_call/dispatch_is_ret ignored; RET entries use BTB target.

Verification
REQ-029 Reset, lookup pred_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
REQ-030 Resolve BR pc=0x200 taken target 0x240 twice, then lookup 0x200 with GHR=0 -> pred_taken=1, pred_target=0x240.
REQ-031 Dispatch 3 branches predicted taken (GHR=0b0000111), mispredict resolve of first (ckpt GHR=0, actual not-taken) -> GHR=0b0000000.
REQ-032 Same cycle: dispatch branch pred taken + mispredict resolve restoring GHR=0b0000101, taken -> GHR=0b0001011.
REQ-033 RAS_EN: dispatch call at 0x300, BTB RET entry at 0x400, lookup 0x400 -> pred_target=0x304; 9 calls with depth 8 -> 8 pops return newest 8, ninth RET uses BTB target.
REQ-034 Counter saturation: 5 taken resolves then 1 not-taken at same index -> counter=2, still predicts taken.
